// File: rtl/coin_pkg.sv
// ---------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin acceptor slice: default debounce hold
// time, debounce counter width and the coin-type encoding used to index the
// per-channel vectors in coin_acceptor.
// ---------------------------------------------------------------------------
package coin_pkg;

    // 20 ms hold at 50 MHz.
    localparam int CNT_MAX_DEF = 999_999;
    // Must satisfy 2**CNT_W > CNT_MAX.
    localparam int CNT_W_DEF   = 20;

    // Coin type doubles as the channel index.
    typedef enum logic {
        COIN_HALF = 1'b0,
        COIN_ONE  = 1'b1
    } coin_t;

    localparam int N_COIN = 2;

endpackage : coin_pkg

// File: rtl/coin_acceptor_if.sv
// ---------------------------------------------------------------------------
// coin_acceptor_if
// Groups the coin acceptor's sensor inputs and accepted-coin outputs.
//   key_half / key_one   : raw active-low coin sensors (asynchronous, bouncing)
//   po_money_half/_one   : one-cycle accepted-coin pulses
//   po_coin_cnt          : running count of accepted coins (wraps at 256)
// master : the sensor side / environment (drives keys, observes outputs)
// slave  : the coin_acceptor itself
// ---------------------------------------------------------------------------
interface coin_acceptor_if;

    logic       key_half;
    logic       key_one;
    logic       po_money_half;
    logic       po_money_one;
    logic [7:0] po_coin_cnt;

    modport master (
        output key_half,
        output key_one,
        input  po_money_half,
        input  po_money_one,
        input  po_coin_cnt
    );

    modport slave (
        input  key_half,
        input  key_one,
        output po_money_half,
        output po_money_one,
        output po_coin_cnt
    );

endinterface : coin_acceptor_if

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
// One coin sensor channel: 2-flop synchronizer, hold-time debounce and
// press (1->0) edge detection.
//   sys_clk  : clock
//   sys_rst  : synchronous active-high reset
//   key_raw  : raw active-low sensor
//   press    : registered one-cycle pulse, one cycle after the debounced
//              level falls; releases produce nothing
// ---------------------------------------------------------------------------
module key_filter
    import coin_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // sync_reg[0] is the metastability flop, sync_reg[1] the usable level.
    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic             stable_next;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             press_reg;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any agreement (a bounce back) restarts it from zero.
    always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        if (sync_reg[1] != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync_reg[1];
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_reg     <= 2'b11;
            stable_reg   <= 1'b1;
            stable_d_reg <= 1'b1;
            cnt_reg      <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], key_raw};
            stable_reg   <= stable_next;
            cnt_reg      <= cnt_next;
            stable_d_reg <= stable_reg;
            // Compare against the delayed copy so the event lands one cycle
            // after the stable level falls.
            press_reg    <= stable_d_reg & ~stable_reg;
        end
    end

    assign press = press_reg;

endmodule : key_filter

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Debounces two coin sensors and issues one registered pulse per accepted
// coin, never both in the same cycle (half has priority, the other waits a
// cycle), plus an 8-bit running coin count.
//   sys_clk : clock
//   sys_rst : synchronous active-high reset
//   bus     : coin_acceptor_if.slave (keys in, pulses and count out)
// ---------------------------------------------------------------------------
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    coin_acceptor_if.slave        bus
);

    logic [N_COIN-1:0] key_raw;
    logic [N_COIN-1:0] press;
    logic [N_COIN-1:0] pend_reg;
    logic [N_COIN-1:0] pend_next;
    logic [N_COIN-1:0] grant;
    logic              half_reg;
    logic              one_reg;
    logic [7:0]        cnt_reg;
    logic [7:0]        cnt_next;

    assign key_raw[COIN_HALF] = bus.key_half;
    assign key_raw[COIN_ONE]  = bus.key_one;

    genvar gi;
    generate
        for (gi = 0; gi < N_COIN; gi++) begin : g_chan
            key_filter #(
                .CNT_MAX (CNT_MAX),
                .CNT_W   (CNT_W)
            ) u_filter (
                .sys_clk (sys_clk),
                .sys_rst (sys_rst),
                .key_raw (key_raw[gi]),
                .press   (press[gi])
            );

            // A press while already pending merges; a press in the same
            // cycle as the grant is a new coin and re-arms the flag.
            assign pend_next[gi] = press[gi] | (pend_reg[gi] & ~grant[gi]);
        end
    endgenerate

    // Fixed priority: half first, one is held over to the next cycle.
    always_comb begin
        grant = '0;
        if (pend_reg[COIN_HALF]) begin
            grant[COIN_HALF] = 1'b1;
        end else if (pend_reg[COIN_ONE]) begin
            grant[COIN_ONE] = 1'b1;
        end
    end

    // Counts the pulse cycle itself, so the count trails the pulse by one.
    assign cnt_next = cnt_reg + 8'(half_reg | one_reg);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_reg <= '0;
            half_reg <= 1'b0;
            one_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            half_reg <= grant[COIN_HALF];
            one_reg  <= grant[COIN_ONE];
            cnt_reg  <= cnt_next;
        end
    end

    assign bus.po_money_half = half_reg;
    assign bus.po_money_one  = one_reg;
    assign bus.po_coin_cnt   = cnt_reg;

endmodule : coin_acceptor
